// File: rtl/pll_lock_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer_if
// Purpose  : Lock-status inputs and reset/status outputs of the PLL sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pll_lock_sequencer_if;
   logic       locked;
   logic       restart_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [1:0] retries;
   logic [7:0] lock_losses;
   logic [2:0] state;

   modport master (
      input  locked, restart_req,
      output pll_rst, sys_rst, ready, fail, retries, lock_losses, state
   );

   modport slave (
      output locked, restart_req,
      input  pll_rst, sys_rst, ready, fail, retries, lock_losses, state
   );
endinterface
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Purpose  : Pulses PLL reset, waits for and qualifies lock, then releases
//            the system reset; retries on timeout, re-sequences on lock loss.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int SYNC_STAGES   = 2
) (
   input wire                   refclk,
   input wire                   rst,
   pll_lock_sequencer_if.master bus
);

   localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
   localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic               w_lock_s;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_cnt_clr;
   logic [1:0]         r_retries;
   logic [1:0]         w_retries_nxt;
   logic [7:0]         r_lock_losses;
   logic [7:0]         w_lock_losses_nxt;
   logic               r_pll_rst;
   logic               r_sys_rst;
   logic               r_ready;
   logic               r_fail;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.locked};
      end
   end

   assign w_lock_s = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_next            = r_state;
      w_retries_nxt     = r_retries;
      w_lock_losses_nxt = r_lock_losses;
      if (bus.restart_req) begin
         w_next        = S_PLL_RST;
         w_retries_nxt = 2'd0;
      end else begin
         case (r_state)
            S_PLL_RST: begin
               if (r_cnt == CNT_W'(RST_CYCLES - 1)) w_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               if (w_lock_s) begin
                  w_next = S_STABLE;
               end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                  if (r_retries == 2'(MAX_RETRIES)) begin
                     w_next = S_FAIL;
                  end else begin
                     w_next        = S_PLL_RST;
                     w_retries_nxt = r_retries + 2'd1;
                  end
               end
            end
            S_STABLE: begin
               if (!w_lock_s) begin
                  w_next = S_WAIT_LOCK;
               end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                  w_next = S_RUN;
               end
            end
            S_RUN: begin
               if (!w_lock_s) begin
                  w_next        = S_PLL_RST;
                  w_retries_nxt = 2'd0;
                  if (r_lock_losses != 8'hFF) w_lock_losses_nxt = r_lock_losses + 8'd1;
               end
            end
            S_FAIL: begin
               w_next = S_FAIL;
            end
            default: begin
               w_next = S_PLL_RST;
            end
         endcase
      end
   end

   // A restart from PLL_RST does not change state but must still restart the pulse.
   assign w_cnt_clr = bus.restart_req || (w_next != r_state);

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state       <= S_PLL_RST;
         r_cnt         <= '0;
         r_retries     <= 2'd0;
         r_lock_losses <= 8'd0;
         r_pll_rst     <= 1'b1;
         r_sys_rst     <= 1'b1;
         r_ready       <= 1'b0;
         r_fail        <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_retries     <= w_retries_nxt;
         r_lock_losses <= w_lock_losses_nxt;
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (r_state != S_RUN && r_state != S_FAIL) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         // Outputs decode the next state so they change on the same edge as state.
         r_pll_rst <= (w_next == S_PLL_RST) || (w_next == S_FAIL);
         r_sys_rst <= (w_next != S_RUN);
         r_ready   <= (w_next == S_RUN);
         r_fail    <= (w_next == S_FAIL);
      end
   end

   assign bus.pll_rst     = r_pll_rst;
   assign bus.sys_rst     = r_sys_rst;
   assign bus.ready       = r_ready;
   assign bus.fail        = r_fail;
   assign bus.retries     = r_retries;
   assign bus.lock_losses = r_lock_losses;
   assign bus.state       = r_state;

endmodule
`default_nettype wire
